// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_arbiter
// Purpose  : Multi-master block-RAM controller. CH channels share a single
//            synchronous RAM of 2^AW words of DW bits. Each channel issues a
//            level request and gets a one-cycle ready pulse when its access
//            completes. Grants rotate round-robin starting after the channel
//            served last. WAIT extra cycles may be added to every access.
// Ports    : clock    - system clock, all logic on its rising edge
//            reset    - asynchronous, active-high reset
//            req      - [CH]     per-channel request (level)
//            we       - [CH]     per-channel write enable, sampled with req
//            address  - [CH*AW]  channel c at [c*AW +: AW]
//            din      - [CH*DW]  write data, channel c at [c*DW +: DW]
//            dout     - [DW]     shared read data, valid while ready is high
//            ready    - [CH]     one-hot completion pulse for served channel
//            busy     - high whenever the controller is not idle
// Revision : 1.0 - initial release
// ============================================================================
module bram_arbiter #(
    parameter int    AW   = 20,
    parameter int    DW   = 8,
    parameter int    CH   = 2,
    parameter int    WAIT = 0,
    parameter string INIT = ""
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CH-1:0]    req,
    input  logic [CH-1:0]    we,
    input  logic [CH*AW-1:0] address,
    input  logic [CH*DW-1:0] din,
    output logic [DW-1:0]    dout,
    output logic [CH-1:0]    ready,
    output logic             busy
);

    // Channel index width; a single channel still needs a 1-bit index.
    localparam int GW = (CH > 1) ? $clog2(CH) : 1;
    // One extra bit so ptr + k can exceed CH-1 before wrapping.
    localparam int CW = GW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;
    logic [3:0]      r_cnt;
    logic [CH-1:0]   r_ready;
    logic            r_busy;
    logic            r_dout_en;
    logic [DW-1:0]   r_rd;

    logic [GW-1:0]   w_grant;
    logic [CW-1:0]   w_cand;
    logic            w_sel_we;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic            w_do_op;
    logic [GW-1:0]   w_next_ptr;

    logic [DW-1:0]   mem [0:(2**AW)-1];

    // Cyclic search from r_ptr: walk candidates from farthest to nearest so
    // the nearest requesting channel (lowest offset k) is the one kept.
    always_comb begin
        w_grant = '0;
        w_cand  = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + CW'(k);
            if (w_cand >= CW'(CH)) begin
                w_cand = w_cand - CW'(CH);
            end
            if (req[w_cand[GW-1:0]]) begin
                w_grant = w_cand[GW-1:0];
            end
        end
    end

    // Pick the granted channel's request fields for latching.
    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int c = 0; c < CH; c++) begin
            if (w_grant == GW'(c)) begin
                w_sel_we   = we[c];
                w_sel_addr = address[c*AW +: AW];
                w_sel_data = din[c*DW +: DW];
            end
        end
    end

    // Pointer moves to the channel after the one just served.
    always_comb begin
        if (CH == 1) begin
            w_next_ptr = '0;
        end else if (r_grant == GW'(CH - 1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_grant + GW'(1);
        end
    end

    // Array operation happens on the edge that leaves ACCESS. Because this
    // is decoded from reset-cleared state, a reset before that edge aborts
    // the write without touching the array.
    assign w_do_op = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_ptr     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_cnt     <= 4'd0;
            r_ready   <= '0;
            r_busy    <= 1'b0;
            r_dout_en <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant <= w_grant;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_data  <= w_sel_data;
                        r_cnt   <= 4'(WAIT);
                        r_busy  <= 1'b1;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ready   <= CH'(1) << r_grant;
                        r_dout_en <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_ready <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_next_ptr;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Synchronous, write-first RAM port without reset so it maps onto block
    // RAM; a write echoes its own data on the read register.
    always_ff @(posedge clock) begin
        if (w_do_op) begin
            if (r_we) begin
                mem[r_addr] <= r_data;
                r_rd        <= r_data;
            end else begin
                r_rd <= mem[r_addr];
            end
        end
    end

    // The RAM output register has no reset, so dout is gated by a
    // reset-cleared flag to present zero until the first access completes.
    assign dout  = r_dout_en ? r_rd : '0;
    assign ready = r_ready;
    assign busy  = r_busy;

endmodule
`default_nettype wire
